multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: five-state multicycle integer core executing RV32I-style
// register/register and register/immediate ALU instructions. One instruction is
// fetched, decoded, executed and written back before the next fetch starts.
module multicycle_datapath #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    output logic            retire,
    output logic            illegal,
    input  logic [4:0]      dbg_ra,
    output logic [XLEN-1:0] dbg_rd
);

    localparam int unsigned RegAw = $clog2(NREG);
    localparam int unsigned ShW   = $clog2(XLEN);
    // Register count widened to 6 bits so index checks also work when NREG = 32.
    localparam logic [5:0]  NregW = 6'(NREG);

    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StTrap
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic            rf_we;

    // Instruction fields, always taken from the latched IR.
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_reg;
    logic       is_imm;
    logic       legal;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign is_reg = (opcode == OpReg);
    assign is_imm = (opcode == OpImm);

    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign imm_sext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    // x0 is never written, so a plain array read already yields zero for it.
    assign rs1_val  = regs_q[rs1[RegAw-1:0]];
    assign rs2_val  = regs_q[rs2[RegAw-1:0]];

    // Legality: known opcode, valid funct3/funct7 pairing, register indices in range.
    always_comb begin
        legal = 1'b0;
        if (is_reg) begin
            legal = (funct7 == F7Zero) ||
                    ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            if ({1'b0, rs2} >= NregW) begin
                legal = 1'b0;
            end
        end else if (is_imm) begin
            case (funct3)
                3'b001:  legal = (funct7 == F7Zero);
                3'b101:  legal = (funct7 == F7Zero) || (funct7 == F7Alt);
                default: legal = 1'b1;
            endcase
        end
        if (({1'b0, rs1} >= NregW) || ({1'b0, rd} >= NregW)) begin
            legal = 1'b0;
        end
    end

    logic [ShW-1:0]  shamt;
    logic            alt;
    logic [XLEN-1:0] alu_res;

    // ALU on the latched operands; funct7 bit 5 selects SUB/SRA variants.
    always_comb begin
        shamt   = is_reg ? b_q[ShW-1:0] : ShW'(rs2);
        alt     = funct7[5];
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (is_reg && alt) ? (a_q - b_q) : (a_q + b_q);
            3'b001:  alu_res = a_q << shamt;
            3'b010:  alu_res = XLEN'($signed(a_q) < $signed(b_q));
            3'b011:  alu_res = XLEN'(a_q < b_q);
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = alt ? $unsigned($signed(a_q) >>> shamt) : (a_q >> shamt);
            3'b110:  alu_res = a_q | b_q;
            default: alu_res = a_q & b_q;
        endcase
    end

    // Next-state and datapath register updates; stall freezes every state past FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        rf_we   = 1'b0;
        case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!stall) begin
                    if (!legal) begin
                        state_d = StTrap;
                    end else begin
                        a_d     = rs1_val;
                        b_d     = is_reg ? rs2_val : imm_sext;
                        state_d = StExecute;
                    end
                end
            end
            StExecute: begin
                if (!stall) begin
                    r_d     = alu_res;
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                if (!stall) begin
                    rf_we   = (rd != 5'd0);
                    pc_d    = pc_q + XLEN'(4);
                    state_d = StFetch;
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
        end
    end

    // Architectural register file; cleared on reset, x0 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rd[RegAw-1:0]] <= r_q;
        end
    end

    // Fetch request is masked during reset so it first appears as reset rises.
    assign imem_req  = reset && (state_q == StFetch);
    assign imem_addr = pc_q;
    assign retire    = (state_q == StWriteback) && !stall;
    assign illegal   = (state_q == StTrap);
    assign dbg_rd    = (({1'b0, dbg_ra} >= NregW) || (dbg_ra == 5'd0)) ? '0
                                                                       : regs_q[dbg_ra[RegAw-1:0]];

endmodule
